// File: rtl/mem_access_ctrl_pkg.sv
// Shared state and owner encodings for the memory access controller.
// The counter width also bounds the range of WAIT_CYCLES.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Purpose: loadable down-counter that times the wait states of one memory access.
// Latency: load takes effect at the next edge; zero is combinational from the count.
// Backpressure: none; the counter holds at zero until it is reloaded.
module mem_access_ctrl_wait_timer
    import mem_access_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: arbitrates the single-port memory between data accesses and instruction fetch.
// Latency: grant edge k, ACCESS for WAIT_CYCLES+1 cycles, done pulse in cycle k+WAIT_CYCLES+1.
// Backpressure: stall freezes the pipeline while a request is pending or being served.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enable,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              Intr_fetch,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              d_done,
    output logic              if_done,
    output logic              stall,
    output logic              err,
    output logic              m_ce,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

    state_t state;
    owner_t owner;
    logic   data_req;
    logic   fetch_req;
    logic   proto_bad;
    logic   grant;
    logic   tmr_zero;
    logic   other_req;

    assign data_req  = mem_enable & (mem_read ^ mem_write);
    assign fetch_req = Intr_fetch;
    assign proto_bad = mem_enable & mem_read & mem_write;
    assign grant     = (state == ST_IDLE) & (data_req | fetch_req);
    assign other_req = (owner == OWN_DATA) ? fetch_req : data_req;

    mem_access_ctrl_wait_timer u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (WAIT_LD),
        .dec      (state == ST_ACCESS),
        .zero     (tmr_zero)
    );

    // Gated by rst so the pipeline is released the instant reset asserts.
    assign stall = rst & ((state == ST_ACCESS) |
                          ((state == ST_IDLE) & (data_req | fetch_req)) |
                          ((state == ST_DONE) & other_req));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_DATA;
            m_ce    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            d_rdata <= '0;
            instr   <= '0;
            d_done  <= 1'b0;
            if_done <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (proto_bad) begin
                        err <= 1'b1;
                    end
                    if (data_req) begin
                        state   <= ST_ACCESS;
                        owner   <= OWN_DATA;
                        m_ce    <= 1'b1;
                        m_we    <= mem_write;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (fetch_req) begin
                        state  <= ST_ACCESS;
                        owner  <= OWN_FETCH;
                        m_ce   <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= pc_addr;
                    end
                end
                ST_ACCESS: begin
                    if (tmr_zero) begin
                        state <= ST_DONE;
                        m_ce  <= 1'b0;
                        m_we  <= 1'b0;
                        if (owner == OWN_DATA) begin
                            d_done <= 1'b1;
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end else begin
                            if_done <= 1'b1;
                            instr   <= m_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    d_done  <= 1'b0;
                    if_done <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
